// File: rtl/mprj_io_cfg_sequencer.sv
// Serial configuration sequencer for the mprj_io pad-control daisy chain:
// chain reset, one CFG_BITS word per pad shifted MSB first, then a common load strobe.
module mprj_io_cfg_sequencer #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 4,
    localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_data,
    output logic                serial_resetn,
    output logic                serial_clock,
    output logic                serial_data_out,
    output logic                serial_load
);

    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CRST  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_LOAD  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);
    localparam logic [AW-1:0] PAD_LAST = AW'(NUM_PADS - 1);

    logic [2:0]          state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic                phase_q, phase_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [AW-1:0]       pad_q, pad_d;
    logic [CFG_BITS-1:0] shreg_q, shreg_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] cfg_addr_q, cfg_addr_d;
    logic          serial_resetn_q, serial_resetn_d;
    logic          serial_clock_q, serial_clock_d;
    logic          serial_data_out_q, serial_data_out_d;
    logic          serial_load_q, serial_load_d;

    logic div_end;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        pad_d   = pad_q;
        shreg_d = shreg_q;
        div_end = (div_q == DIV_LAST);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CRST;
                    div_d   = '0;
                    pad_d   = PAD_LAST;
                end
            end
            S_CRST: begin
                if (div_end) begin
                    state_d = S_FETCH;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                state_d = S_SHIFT;
                shreg_d = cfg_data;
                bit_d   = BIT_LAST;
                phase_d = 1'b0;
                div_d   = '0;
            end
            S_SHIFT: begin
                // Each bit is a low phase then a high phase; data moves only at the bit boundary.
                if (!div_end) begin
                    div_d = div_q + DW'(1);
                end else begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        shreg_d = shreg_q << 1;
                        if (bit_q == '0) begin
                            if (pad_q == '0) begin
                                state_d = S_LOAD;
                            end else begin
                                pad_d   = pad_q - AW'(1);
                                state_d = S_FETCH;
                            end
                        end else begin
                            bit_d = bit_q - BW'(1);
                        end
                    end
                end
            end
            S_LOAD: begin
                if (div_end) begin
                    state_d = S_DONE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        busy_d            = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d            = (state_d == S_DONE);
        cfg_addr_d        = (state_d == S_FETCH) ? pad_d : cfg_addr_q;
        serial_resetn_d   = (state_d != S_CRST);
        serial_clock_d    = (state_d == S_SHIFT) && phase_d;
        serial_data_out_d = (state_d == S_SHIFT) ? shreg_d[CFG_BITS-1] : 1'b0;
        serial_load_d     = (state_d == S_LOAD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= S_IDLE;
            div_q             <= '0;
            phase_q           <= 1'b0;
            bit_q             <= '0;
            pad_q             <= '0;
            shreg_q           <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            cfg_addr_q        <= '0;
            serial_resetn_q   <= 1'b1;
            serial_clock_q    <= 1'b0;
            serial_data_out_q <= 1'b0;
            serial_load_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            div_q             <= div_d;
            phase_q           <= phase_d;
            bit_q             <= bit_d;
            pad_q             <= pad_d;
            shreg_q           <= shreg_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            cfg_addr_q        <= cfg_addr_d;
            serial_resetn_q   <= serial_resetn_d;
            serial_clock_q    <= serial_clock_d;
            serial_data_out_q <= serial_data_out_d;
            serial_load_q     <= serial_load_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign cfg_addr        = cfg_addr_q;
    assign serial_resetn   = serial_resetn_q;
    assign serial_clock    = serial_clock_q;
    assign serial_data_out = serial_data_out_q;
    assign serial_load     = serial_load_q;

endmodule

// File: tb/tb_mprj_io_cfg_sequencer.sv
// Bench for mprj_io_cfg_sequencer: three parameterisations driven by random store
// contents, checked against a shift-chain model and sequence timing derived from the rules.
`timescale 1ns/1ps
module tb_mprj_io_cfg_sequencer;

    localparam int NP  = 38, CB  = 13, CD  = 4;
    localparam int NP1 = 2,  CB1 = 4,  CD1 = 1;
    localparam int NP5 = 2,  CB5 = 3,  CD5 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start0, start1, start5;

    logic          busy0, done0, rn0, sc0, sd0, ld0;
    logic [5:0]    cfg_addr0;
    logic [CB-1:0] cfg_data0;
    logic [CB-1:0] store0 [NP];
    logic [CB-1:0] exp0 [NP];
    logic [CB-1:0] loaded0 [NP];

    logic           busy1, done1, rn1, sc1, sd1, ld1;
    logic [0:0]     cfg_addr1;
    logic [CB1-1:0] cfg_data1;
    logic [CB1-1:0] store1 [NP1];

    logic           busy5, done5, rn5, sc5, sd5, ld5;
    logic [0:0]     cfg_addr5;
    logic [CB5-1:0] cfg_data5;
    logic [CB5-1:0] store5 [NP5];

    always @(posedge clk) cfg_data0 <= store0[cfg_addr0];
    always @(posedge clk) cfg_data1 <= store1[cfg_addr1];
    always @(posedge clk) cfg_data5 <= store5[cfg_addr5];

    mprj_io_cfg_sequencer #(.NUM_PADS(NP), .CFG_BITS(CB), .CLK_DIV(CD)) u_dut0 (
        .clock(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
        .cfg_addr(cfg_addr0), .cfg_data(cfg_data0), .serial_resetn(rn0),
        .serial_clock(sc0), .serial_data_out(sd0), .serial_load(ld0));

    mprj_io_cfg_sequencer #(.NUM_PADS(NP1), .CFG_BITS(CB1), .CLK_DIV(CD1)) u_dut1 (
        .clock(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .cfg_addr(cfg_addr1), .cfg_data(cfg_data1), .serial_resetn(rn1),
        .serial_clock(sc1), .serial_data_out(sd1), .serial_load(ld1));

    mprj_io_cfg_sequencer #(.NUM_PADS(NP5), .CFG_BITS(CB5), .CLK_DIV(CD5)) u_dut5 (
        .clock(clk), .reset(reset), .start(start5), .busy(busy5), .done(done5),
        .cfg_addr(cfg_addr5), .cfg_data(cfg_data5), .serial_resetn(rn5),
        .serial_clock(sc5), .serial_data_out(sd5), .serial_load(ld5));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic int lat(input int np, input int cb, input int cd);
        return 1 + cd + np * (2 + 2 * cd * cb) + cd;
    endfunction

    typedef struct {
        int cycle; int rises; int hi_run; int lo_run; bit seen_fall;
        int bad_hi; int bad_lo; int lo_cd; int lo_cd2; int data_bad;
        int load_cyc; int load_evt; int load_last; int rstn_low;
        int done_cnt; int done_cycle; int busy_bad;
        bit prev_sc; bit prev_sd; bit prev_ld;
    } mon_t;

    mon_t m0, m1, m5;
    bit q0[$], q1[$], q5[$];

    function automatic void mon_step(inout mon_t m, input int cd, input logic sc, input logic sd,
                                     input logic ld, input logic rn, input logic dn, input logic bsy);
        if (sc && !m.prev_sc) begin
            m.rises++;
            if (m.seen_fall) begin
                if (m.lo_run == cd) m.lo_cd++;
                else if (m.lo_run == cd + 2) m.lo_cd2++;
                else m.bad_lo++;
            end
            m.hi_run = 1;
        end else if (sc) begin
            m.hi_run++;
        end else if (m.prev_sc) begin
            if (m.hi_run != cd) m.bad_hi++;
            m.seen_fall = 1'b1;
            m.lo_run = 1;
        end else begin
            m.lo_run++;
        end
        if ((sd !== m.prev_sd) && sc) m.data_bad++;
        if (ld) begin m.load_cyc++; m.load_last = m.cycle; end
        if (ld && !m.prev_ld) m.load_evt++;
        if (!rn) m.rstn_low++;
        if (dn) begin m.done_cnt++; m.done_cycle = m.cycle; end
        if (dn && bsy) m.busy_bad++;
        if (m.cycle >= 1 && m.done_cnt == 0 && !dn && !bsy) m.busy_bad++;
        m.prev_sc = sc; m.prev_sd = sd; m.prev_ld = ld;
        m.cycle++;
    endfunction

    int mon0_idx;
    logic [CB-1:0] mon0_w;

    // Chain model: bits enter at the driver end, so pad 0 holds the last word shifted.
    always @(negedge clk) begin
        if (!rn0) q0.delete();
        else if (sc0 && !m0.prev_sc) q0.push_back(sd0);
        if (ld0 && !m0.prev_ld) begin
            for (int p = 0; p < NP; p++) begin
                mon0_w = '0;
                for (int j = 0; j < CB; j++) begin
                    mon0_idx = q0.size() - (p + 1) * CB + j;
                    mon0_w = {mon0_w[CB-2:0], (mon0_idx >= 0) ? q0[mon0_idx] : 1'b0};
                end
                loaded0[p] = mon0_w;
            end
        end
        mon_step(m0, CD, sc0, sd0, ld0, rn0, done0, busy0);
    end

    always @(negedge clk) begin
        if (!rn1) q1.delete();
        else if (sc1 && !m1.prev_sc) q1.push_back(sd1);
        mon_step(m1, CD1, sc1, sd1, ld1, rn1, done1, busy1);
    end

    always @(negedge clk) begin
        if (!rn5) q5.delete();
        else if (sc5 && !m5.prev_sc) q5.push_back(sd5);
        mon_step(m5, CD5, sc5, sd5, ld5, rn5, done5, busy5);
    end

    function automatic bit cond(input int sel, input int k);
        case (sel)
            0: return done0;
            1: return done1;
            2: return done5;
            3: return (int'(cfg_addr0) == k) && sc0;
            default: return m0.rises >= k;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input int k, input int budget, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            hit = cond(sel, k);
        end
        if (!hit) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic launch0();
        @(posedge clk); #1;
        m0 = '{default: 0};
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
    endtask

    task automatic check_run0(input string tag);
        #1;
        chk({tag, "_latency"}, m0.done_cycle, lat(NP, CB, CD));
        chk({tag, "_rises"}, m0.rises, NP * CB);
        chk({tag, "_hi_width"}, m0.bad_hi, 0);
        chk({tag, "_lo_width"}, m0.bad_lo, 0);
        chk({tag, "_lo_in_pad"}, m0.lo_cd, NP * (CB - 1));
        chk({tag, "_lo_between"}, m0.lo_cd2, NP - 1);
        chk({tag, "_data_stable"}, m0.data_bad, 0);
        chk({tag, "_load_cyc"}, m0.load_cyc, CD);
        chk({tag, "_load_evt"}, m0.load_evt, 1);
        chk({tag, "_rstn_low"}, m0.rstn_low, CD);
        chk({tag, "_busy"}, m0.busy_bad, 0);
        for (int p = 0; p < NP; p++) chk($sformatf("%s_word%0d", tag, p), loaded0[p], exp0[p]);
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_done_once"}, m0.done_cnt, 1);
        chk({tag, "_idle_busy"}, busy0, 0);
    endtask

    task automatic fill_store0();
        for (int p = 0; p < NP; p++) begin
            store0[p] = CB'($urandom);
            exp0[p] = store0[p];
        end
    endtask

    logic [7:0] t1_bits;
    logic [CB5-1:0] w5;
    logic [CB-1:0] newv;

    initial begin
        reset = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start5 = 1'b0;
        fill_store0();
        store1[1] = 4'hA; store1[0] = 4'h5;
        for (int p = 0; p < NP5; p++) store5[p] = CB5'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_addr", cfg_addr0, 0);
        chk("rst_resetn", rn0, 1);
        chk("rst_sclk", sc0, 0);
        chk("rst_sdata", sd0, 0);
        chk("rst_load", ld0, 0);
        reset = 1'b0;

        // Small chain, one cycle per phase: known bit pattern and latency.
        @(posedge clk); #1;
        m1 = '{default: 0};
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        wait_cond(1, 0, 200, "t1");
        #1;
        t1_bits = 8'b1010_0101;
        chk("t1_nbits", q1.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t1_bit%0d", i), (i < q1.size()) ? q1[i] : 1'bx, t1_bits[7-i]);
        chk("t1_latency", m1.done_cycle, lat(NP1, CB1, CD1));
        chk("t1_load_cyc", m1.load_cyc, 1);
        chk("t1_load_then_done", m1.load_last, m1.done_cycle - 1);
        chk("t1_done", m1.done_cnt, 1);

        // Three cycles per phase.
        @(posedge clk); #1;
        m5 = '{default: 0};
        start5 = 1'b1;
        @(posedge clk); #1;
        start5 = 1'b0;
        wait_cond(2, 0, 500, "t5");
        #1;
        chk("t5_rises", m5.rises, NP5 * CB5);
        chk("t5_hi_width", m5.bad_hi, 0);
        chk("t5_lo_width", m5.bad_lo, 0);
        chk("t5_lo_in_pad", m5.lo_cd, NP5 * (CB5 - 1));
        chk("t5_data_stable", m5.data_bad, 0);
        chk("t5_load_cyc", m5.load_cyc, CD5);
        chk("t5_latency", m5.done_cycle, lat(NP5, CB5, CD5));
        for (int p = 0; p < NP5; p++) begin
            w5 = '0;
            for (int j = 0; j < CB5; j++) begin
                int idx;
                idx = q5.size() - (p + 1) * CB5 + j;
                w5 = {w5[CB5-2:0], (idx >= 0) ? q5[idx] : 1'b0};
            end
            chk($sformatf("t5_word%0d", p), w5, store5[p]);
        end

        // Full default chain.
        launch0();
        wait_cond(0, 0, 6000, "t2");
        check_run0("t2");

        // Starts during SHIFT and DONE are dropped.
        fill_store0();
        launch0();
        wait_cond(4, 5, 6000, "t3_shift");
        @(posedge clk); #1; start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        wait_cond(0, 0, 6000, "t3");
        start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        check_run0("t3");
        fill_store0();
        launch0();
        wait_cond(0, 0, 6000, "t3b");
        check_run0("t3b");

        // Abort during pad 20.
        fill_store0();
        launch0();
        wait_cond(3, 20, 6000, "t4_pad20");
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1;
        chk("t4_busy", busy0, 0);
        chk("t4_done", done0, 0);
        chk("t4_addr", cfg_addr0, 0);
        chk("t4_resetn", rn0, 1);
        chk("t4_sclk", sc0, 0);
        chk("t4_sdata", sd0, 0);
        chk("t4_load", ld0, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("t4_no_load", m0.load_evt, 0);
        chk("t4_no_done", m0.done_cnt, 0);
        launch0();
        wait_cond(0, 0, 6000, "t4b");
        check_run0("t4b");

        // Store rewritten while pad 10 shifts.
        fill_store0();
        launch0();
        wait_cond(3, 10, 6000, "t6_pad10");
        for (int p = 0; p < NP; p++) begin
            newv = CB'($urandom);
            store0[p] = newv;
            if (p < 10) exp0[p] = newv;
        end
        wait_cond(0, 0, 6000, "t6");
        check_run0("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
